fetch_seq: RTL and testbench
============================

Name: fetch_seq

Overview:
- Sequential instruction-fetch and next-PC unit: the consuming end of the decoder's NPCOp interface.
- Holds the PC and fetches each instruction from instruction memory over a req/ack handshake.
- Presents the instruction to the decoder and datapath, then, when the datapath signals completion, computes the next PC from NPCOp and the operands.
- Sits between IM and the control/datapath of the multi-cycle-fetch SCCPU variant.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge
- rstn  input  1  asynchronous active-low reset
- imem_req  output  1  fetch request to instruction memory
- imem_addr  output  32  fetch address; equals PC
- imem_ack  input  1  IM data valid this cycle
- imem_rdata  input  32  instruction word from IM
- instr  output  32  latched instruction to decoder/datapath
- instr_valid  output  1  instr valid, awaiting execution
- pc  output  32  PC of current instruction
- pc_plus4  output  32  pc+4, for jal/jalr link writeback
- exec_done  input  1  datapath finished current instruction this cycle
- npc_op  input  2  00 PLUS4, 01 BRANCH, 10 JUMP, 11 JUMPR; sampled with exec_done
- rs_val  input  32  register rs value, for JUMPR
- retire_cnt  output  CNT_W  count of completed instructions
- fetch_err  output  1  misalignment trap; only with the optional feature

Behaviour:
- Reset (rstn low, asynchronous):
  - pc=RESET_PC, state=FETCH.
  - imem_req=0, instr=0, instr_valid=0, retire_cnt=0, fetch_err=0.
  - Reset mid-handshake abandons the fetch; any in-flight ack after release is ignored until imem_req is reasserted.
- States: FETCH, WAIT, ISSUE, TRAP (TRAP only when the feature is compiled in).
- FETCH: one cycle; set imem_req=1 and go to WAIT. imem_addr=pc at all times.
- WAIT:
  - imem_req held 1 and imem_addr stable until imem_ack.
  - On ack: instr<=imem_rdata, imem_req<=0, instr_valid<=1, go to ISSUE.
  - Latency is ack+1 cycles; a zero-wait IM (ack on the first WAIT cycle) gives 2 cycles from FETCH to instr_valid.
- ISSUE:
  - instr_valid=1, instr stable.
  - On exec_done: pc<=next_pc, instr_valid<=0, retire_cnt<=retire_cnt+1 (wraps modulo 2^CNT_W), go to FETCH.
  - With exec_done low: hold indefinitely.
- exec_done outside ISSUE: ignored.
- imem_ack outside WAIT: ignored.
- next_pc, all 32-bit, combinational from pc, instr, npc_op, rs_val:
  - PLUS4: pc+4, wrapping 32'hFFFF_FFFC to 0.
  - BRANCH: pc+4 + ({{14{instr[15]}},instr[15:0],2'b00}); the decoder only issues BRANCH when beq is taken.
  - JUMP: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - JUMPR: rs_val.
- pc_plus4 = pc+4, combinational.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined:
  - On exec_done, if next_pc[1:0]!=0 (only JUMPR can cause this), pc still loads next_pc, retire_cnt still increments, and the unit enters TRAP.
  - TRAP: fetch_err=1, imem_req=0, instr_valid=0.
  - Leaves TRAP only on reset.
- Undefined:
  - pc loads {next_pc[31:2],2'b00}.
  - fetch_err tied 0.
  - No TRAP state.

Decomposition:
- Package fetch_pkg:
  - NPC_PLUS4/NPC_BRANCH/NPC_JUMP/NPC_JUMPR constants, matching the decoder's NPCOp encoding.
  - State encodings.
  - 32-bit word typedef.
- Sub-module npc_calc: combinational next_pc from pc, imm16, target26, rs_val, npc_op; reused by a future pipelined fetch.

Test Plan:
- Reset, IM acks after 3 wait cycles with rdata 32'h2008_0005 -> imem_addr=0, instr_valid rises 1 cycle after ack with instr=32'h2008_0005; exec_done with PLUS4 -> pc=4, retire_cnt=1.
- pc=32'h0000_0010, instr imm16=16'hFFFE, npc_op=BRANCH -> pc=32'h0000_000C.
- pc=32'h0000_3004, instr[25:0]=26'h0000C03, npc_op=JUMP -> pc=32'h0000_300C; JUMPR with rs_val=32'h0000_3020 -> pc=32'h0000_3020.
- exec_done pulsed in WAIT and a spurious ack in ISSUE -> no state, pc or instr change; rstn low during WAIT -> all outputs at reset values immediately; refetch from RESET_PC.
- JUMPR rs_val=32'h0000_3022 -> with FETCH_ALIGN_CHECK_EN: fetch_err=1, no further imem_req; without: pc=32'h0000_3020.
- retire_cnt preset via 2^CNT_W-1 retirements (CNT_W=4 build: 15 instructions) -> the next exec_done wraps it to 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// +---------------------------------------------------------------------------+
// | fetch_pkg: shared types and encodings for the fetch/next-PC unit.         |
// | Rev 1.0 - initial release                                                 |
// +---------------------------------------------------------------------------+
`default_nettype none

package fetch_pkg;

  typedef logic [31:0] word_t;

  // Must track the decoder's NPCOp encoding.
  localparam logic [1:0] NPC_PLUS4  = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;
  localparam logic [1:0] NPC_JUMPR  = 2'b11;

`ifdef FETCH_ALIGN_CHECK_EN
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_TRAP  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ISSUE = 2'd2
  } state_t;
`endif

endpackage

`default_nettype wire

// File: rtl/fetch_seq_if.sv
// +---------------------------------------------------------------------------+
// | fetch_seq_if: instruction-memory req/ack fetch port.                      |
// | Rev 1.0 - initial release                                                 |
// +---------------------------------------------------------------------------+
`default_nettype none

interface fetch_seq_if;
  import fetch_pkg::*;

  logic  req;
  word_t addr;
  logic  ack;
  word_t rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);

endinterface

`default_nettype wire

// File: rtl/npc_calc.sv
// +---------------------------------------------------------------------------+
// | npc_calc: combinational next-PC selection (PLUS4/BRANCH/JUMP/JUMPR).      |
// | Rev 1.0 - initial release                                                 |
// +---------------------------------------------------------------------------+
`default_nettype none

module npc_calc
  import fetch_pkg::*;
(
  input  word_t       pc,
  input  logic [15:0] imm16,
  input  logic [25:0] target26,
  input  word_t       rs_val,
  input  logic [1:0]  npc_op,
  output word_t       pc_plus4,
  output word_t       next_pc
);

  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    next_pc = pc_plus4;
    case (npc_op)
      NPC_PLUS4:  next_pc = pc_plus4;
      NPC_BRANCH: next_pc = pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};
      NPC_JUMP:   next_pc = {pc_plus4[31:28], target26, 2'b00};
      NPC_JUMPR:  next_pc = rs_val;
      default:    next_pc = pc_plus4;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/fetch_seq.sv
// +---------------------------------------------------------------------------+
// | fetch_seq: multi-cycle instruction fetch and PC sequencing unit.          |
// | Optional misalignment trap: define FETCH_ALIGN_CHECK_EN.                  |
// | Rev 1.0 - initial release                                                 |
// +---------------------------------------------------------------------------+
`default_nettype none

module fetch_seq
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rstn,
  fetch_seq_if.master      imem,
  output word_t            instr,
  output logic             instr_valid,
  output word_t            pc,
  output word_t            pc_plus4,
  input  logic             exec_done,
  input  logic [1:0]       npc_op,
  input  word_t            rs_val,
  output logic [CNT_W-1:0] retire_cnt,
  output logic             fetch_err
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_nxt;
  word_t            r_pc;
  word_t            r_instr;
  logic             r_instr_valid;
  logic             r_req;
  logic [CNT_W-1:0] r_cnt;
  logic             w_load_instr;
  logic             w_retire;
  word_t            w_next_pc;
  word_t            w_pc_plus4;

  npc_calc u_npc_calc (
    .pc       (r_pc),
    .imm16    (r_instr[15:0]),
    .target26 (r_instr[25:0]),
    .rs_val   (rs_val),
    .npc_op   (npc_op),
    .pc_plus4 (w_pc_plus4),
    .next_pc  (w_next_pc)
  );

`ifdef FETCH_ALIGN_CHECK_EN
  logic r_err;
  logic w_misalign;
  assign w_misalign = |w_next_pc[1:0];
  assign fetch_err  = r_err;
`else
  assign fetch_err  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_FETCH;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_load_instr = 1'b0;
    w_retire     = 1'b0;
    case (r_state)
      ST_FETCH: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (imem.ack) begin
          w_load_instr = 1'b1;
          w_state_nxt  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (exec_done) begin
          w_retire    = 1'b1;
          w_state_nxt = ST_FETCH;
`ifdef FETCH_ALIGN_CHECK_EN
          if (w_misalign) w_state_nxt = ST_TRAP;
`endif
        end
      end
`ifdef FETCH_ALIGN_CHECK_EN
      ST_TRAP: w_state_nxt = ST_TRAP;
`endif
      default: w_state_nxt = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pc          <= RESET_PC;
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
      r_req         <= 1'b0;
      r_cnt         <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
      r_err         <= 1'b0;
`endif
    end else begin
      // Request is high for exactly the WAIT residency.
      r_req <= (w_state_nxt == ST_WAIT);
      if (w_load_instr) begin
        r_instr       <= imem.rdata;
        r_instr_valid <= 1'b1;
      end
      if (w_retire) begin
`ifdef FETCH_ALIGN_CHECK_EN
        r_pc <= w_next_pc;
        if (w_misalign) r_err <= 1'b1;
`else
        r_pc <= w_next_pc & ~32'd3;
`endif
        r_instr_valid <= 1'b0;
        r_cnt         <= r_cnt + CNT_ONE;
      end
    end
  end

  assign imem.req    = r_req;
  assign imem.addr   = r_pc;
  assign instr       = r_instr;
  assign instr_valid = r_instr_valid;
  assign pc          = r_pc;
  assign pc_plus4    = w_pc_plus4;
  assign retire_cnt  = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_fetch_seq.sv
// +---------------------------------------------------------------------------+
// | tb_fetch_seq: directed self-checking bench for fetch_seq (CNT_W=4).       |
// | Rev 1.0 - initial release                                                 |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_fetch_seq;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] instr, pc, pc_plus4, rs_val;
  logic        instr_valid, exec_done, fetch_err;
  logic [1:0]  npc_op;
  logic [3:0]  retire_cnt;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  fetch_seq_if imem ();

  fetch_seq #(.RESET_PC(32'h0000_0000), .CNT_W(4)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .imem        (imem),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .exec_done   (exec_done),
    .npc_op      (npc_op),
    .rs_val      (rs_val),
    .retire_cnt  (retire_cnt),
    .fetch_err   (fetch_err)
  );

  task automatic wait_req(input string tag);
    int n = 0;
    while (imem.req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (imem.req !== 1'b1) begin
      bad++;
      $display("FAIL %s_req_timeout: imem_req=%b want 1", tag, imem.req);
    end
  endtask

  task automatic do_fetch(input logic [31:0] w, input string tag);
    wait_req(tag);
    imem.ack   = 1'b1;
    imem.rdata = w;
    @(negedge clk);
    imem.ack   = 1'b0;
    imem.rdata = 32'hDEAD_BEEF;
  endtask

  task automatic do_retire(input logic [1:0] op, input logic [31:0] rs);
    npc_op    = op;
    rs_val    = rs;
    exec_done = 1'b1;
    @(negedge clk);
    exec_done = 1'b0;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    total += 6;
    if (imem.req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", imem.req); end
    if (instr !== 32'h0) begin bad++; $display("FAIL rst_instr: got %h want 0", instr); end
    if (instr_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
    if (pc !== 32'h0) begin bad++; $display("FAIL rst_pc: got %h want 0", pc); end
    if (retire_cnt !== 4'd0) begin bad++; $display("FAIL rst_cnt: got %0d want 0", retire_cnt); end
    if (fetch_err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", fetch_err); end
    rstn = 1'b1;
  endtask

  task automatic test_first_fetch;
    total++;
    if (imem.req !== 1'b0) begin bad++; $display("FAIL ff_fetch_req: got %b want 0", imem.req); end
    @(negedge clk);
    total += 2;
    if (imem.req !== 1'b1) begin bad++; $display("FAIL ff_wait_req: got %b want 1", imem.req); end
    if (imem.addr !== 32'h0) begin bad++; $display("FAIL ff_addr: got %h want 0", imem.addr); end
    repeat (3) @(negedge clk);
    total += 3;
    if (imem.req !== 1'b1) begin bad++; $display("FAIL ff_req_hold: got %b want 1", imem.req); end
    if (imem.addr !== 32'h0) begin bad++; $display("FAIL ff_addr_hold: got %h want 0", imem.addr); end
    if (instr_valid !== 1'b0) begin bad++; $display("FAIL ff_valid_early: got %b want 0", instr_valid); end
    imem.ack   = 1'b1;
    imem.rdata = 32'h2008_0005;
    @(negedge clk);
    imem.ack   = 1'b0;
    imem.rdata = 32'hDEAD_BEEF;
    total += 3;
    if (instr_valid !== 1'b1) begin bad++; $display("FAIL ff_valid: got %b want 1", instr_valid); end
    if (instr !== 32'h2008_0005) begin bad++; $display("FAIL ff_instr: got %h want 20080005", instr); end
    if (imem.req !== 1'b0) begin bad++; $display("FAIL ff_req_drop: got %b want 0", imem.req); end
    do_retire(NPC_PLUS4, 32'h0);
    total += 3;
    if (pc !== 32'h4) begin bad++; $display("FAIL ff_pc: got %h want 4", pc); end
    if (retire_cnt !== 4'd1) begin bad++; $display("FAIL ff_cnt: got %0d want 1", retire_cnt); end
    if (instr_valid !== 1'b0) begin bad++; $display("FAIL ff_valid_clr: got %b want 0", instr_valid); end
  endtask

  task automatic test_branch;
    for (int i = 0; i < 3; i++) begin
      do_fetch(32'h0, "br_pre");
      do_retire(NPC_PLUS4, 32'h0);
    end
    total++;
    if (pc !== 32'h10) begin bad++; $display("FAIL br_pre_pc: got %h want 10", pc); end
    do_fetch(32'h1000_FFFE, "br");
    total++;
    if (pc_plus4 !== 32'h14) begin bad++; $display("FAIL br_pc4: got %h want 14", pc_plus4); end
    do_retire(NPC_BRANCH, 32'h0);
    total += 2;
    if (pc !== 32'hC) begin bad++; $display("FAIL br_pc: got %h want C", pc); end
    if (retire_cnt !== 4'd5) begin bad++; $display("FAIL br_cnt: got %0d want 5", retire_cnt); end
  endtask

  task automatic test_jump;
    do_fetch(32'h0, "j_pre");
    do_retire(NPC_JUMPR, 32'h0000_3004);
    total++;
    if (pc !== 32'h3004) begin bad++; $display("FAIL jr_pre_pc: got %h want 3004", pc); end
    do_fetch(32'h0800_0C03, "j");
    do_retire(NPC_JUMP, 32'hFFFF_0000);
    total++;
    if (pc !== 32'h300C) begin bad++; $display("FAIL j_pc: got %h want 300C", pc); end
    do_fetch(32'h0, "jr");
    do_retire(NPC_JUMPR, 32'h0000_3020);
    total += 2;
    if (pc !== 32'h3020) begin bad++; $display("FAIL jr_pc: got %h want 3020", pc); end
    if (retire_cnt !== 4'd8) begin bad++; $display("FAIL jr_cnt: got %0d want 8", retire_cnt); end
    do_fetch(32'h0, "wrap_pre");
    do_retire(NPC_JUMPR, 32'hFFFF_FFFC);
    total++;
    if (pc_plus4 !== 32'h0) begin bad++; $display("FAIL wrap_pc4: got %h want 0", pc_plus4); end
    do_fetch(32'h0, "wrap");
    do_retire(NPC_PLUS4, 32'h0);
    total += 2;
    if (pc !== 32'h0) begin bad++; $display("FAIL wrap_pc: got %h want 0", pc); end
    if (retire_cnt !== 4'd10) begin bad++; $display("FAIL wrap_cnt: got %0d want 10", retire_cnt); end
  endtask

  task automatic test_spurious;
    wait_req("sp");
    npc_op    = NPC_JUMPR;
    rs_val    = 32'h0000_1234;
    exec_done = 1'b1;
    @(negedge clk);
    exec_done = 1'b0;
    total += 4;
    if (imem.req !== 1'b1) begin bad++; $display("FAIL sp_wait_req: got %b want 1", imem.req); end
    if (instr_valid !== 1'b0) begin bad++; $display("FAIL sp_wait_valid: got %b want 0", instr_valid); end
    if (pc !== 32'h0) begin bad++; $display("FAIL sp_wait_pc: got %h want 0", pc); end
    if (retire_cnt !== 4'd10) begin bad++; $display("FAIL sp_wait_cnt: got %0d want 10", retire_cnt); end
    do_fetch(32'hAAAA_0001, "sp");
    imem.ack   = 1'b1;
    imem.rdata = 32'h5555_0002;
    @(negedge clk);
    imem.ack   = 1'b0;
    repeat (2) @(negedge clk);
    total += 4;
    if (instr !== 32'hAAAA_0001) begin bad++; $display("FAIL sp_instr: got %h want AAAA0001", instr); end
    if (instr_valid !== 1'b1) begin bad++; $display("FAIL sp_valid: got %b want 1", instr_valid); end
    if (imem.req !== 1'b0) begin bad++; $display("FAIL sp_issue_req: got %b want 0", imem.req); end
    if (pc !== 32'h0) begin bad++; $display("FAIL sp_issue_pc: got %h want 0", pc); end
    do_retire(NPC_PLUS4, 32'h0);
    total++;
    if (pc !== 32'h4) begin bad++; $display("FAIL sp_pc: got %h want 4", pc); end
  endtask

  task automatic test_reset_mid_wait;
    wait_req("rw");
    total++;
    if (imem.addr !== 32'h4) begin bad++; $display("FAIL rw_addr: got %h want 4", imem.addr); end
    rstn = 1'b0;
    #1;
    total += 5;
    if (imem.req !== 1'b0) begin bad++; $display("FAIL rw_req: got %b want 0", imem.req); end
    if (instr !== 32'h0) begin bad++; $display("FAIL rw_instr: got %h want 0", instr); end
    if (instr_valid !== 1'b0) begin bad++; $display("FAIL rw_valid: got %b want 0", instr_valid); end
    if (pc !== 32'h0) begin bad++; $display("FAIL rw_pc: got %h want 0", pc); end
    if (retire_cnt !== 4'd0) begin bad++; $display("FAIL rw_cnt: got %0d want 0", retire_cnt); end
    @(negedge clk);
    rstn       = 1'b1;
    imem.ack   = 1'b1;
    imem.rdata = 32'hBAD0_0BAD;
    @(negedge clk);
    imem.ack   = 1'b0;
    total += 3;
    if (instr_valid !== 1'b0) begin bad++; $display("FAIL rw_stale_ack: valid=%b want 0", instr_valid); end
    if (imem.req !== 1'b1) begin bad++; $display("FAIL rw_refetch_req: got %b want 1", imem.req); end
    if (imem.addr !== 32'h0) begin bad++; $display("FAIL rw_refetch_addr: got %h want 0", imem.addr); end
    do_fetch(32'h2008_0005, "rw");
    total++;
    if (instr !== 32'h2008_0005) begin bad++; $display("FAIL rw_instr2: got %h want 20080005", instr); end
    do_retire(NPC_PLUS4, 32'h0);
  endtask

  task automatic test_counter_wrap;
    for (int i = 0; i < 14; i++) begin
      do_fetch(32'h0, "cw");
      do_retire(NPC_PLUS4, 32'h0);
    end
    total += 2;
    if (retire_cnt !== 4'd15) begin bad++; $display("FAIL cw_cnt15: got %0d want 15", retire_cnt); end
    if (pc !== 32'h3C) begin bad++; $display("FAIL cw_pc: got %h want 3C", pc); end
    do_fetch(32'h0, "cw_last");
    do_retire(NPC_PLUS4, 32'h0);
    total += 2;
    if (retire_cnt !== 4'd0) begin bad++; $display("FAIL cw_cnt0: got %0d want 0", retire_cnt); end
    if (pc !== 32'h40) begin bad++; $display("FAIL cw_pc2: got %h want 40", pc); end
  endtask

  task automatic test_align;
    do_fetch(32'h0, "al");
    do_retire(NPC_JUMPR, 32'h0000_3022);
    total++;
    if (retire_cnt !== 4'd1) begin bad++; $display("FAIL al_cnt: got %0d want 1", retire_cnt); end
`ifdef FETCH_ALIGN_CHECK_EN
    begin
      logic seen_req = 1'b0;
      total += 3;
      if (fetch_err !== 1'b1) begin bad++; $display("FAIL al_err: got %b want 1", fetch_err); end
      if (pc !== 32'h3022) begin bad++; $display("FAIL al_pc: got %h want 3022", pc); end
      if (instr_valid !== 1'b0) begin bad++; $display("FAIL al_valid: got %b want 0", instr_valid); end
      for (int i = 0; i < 6; i++) begin
        if (imem.req !== 1'b0) seen_req = 1'b1;
        @(negedge clk);
      end
      total += 2;
      if (seen_req !== 1'b0) begin bad++; $display("FAIL al_trap_req: saw req=1 want 0"); end
      if (fetch_err !== 1'b1) begin bad++; $display("FAIL al_err_hold: got %b want 1", fetch_err); end
    end
`else
    total += 2;
    if (pc !== 32'h3020) begin bad++; $display("FAIL al_pc: got %h want 3020", pc); end
    if (fetch_err !== 1'b0) begin bad++; $display("FAIL al_err: got %b want 0", fetch_err); end
    wait_req("al");
    total++;
    if (imem.addr !== 32'h3020) begin bad++; $display("FAIL al_addr: got %h want 3020", imem.addr); end
`endif
  endtask

  initial begin
    exec_done  = 1'b0;
    npc_op     = NPC_PLUS4;
    rs_val     = 32'h0;
    imem.ack   = 1'b0;
    imem.rdata = 32'h0;
    test_reset;
    test_first_fetch;
    test_branch;
    test_jump;
    test_spurious;
    test_reset_mid_wait;
    test_counter_wrap;
    test_align;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
